vram_write_fifo: RTL and testbench
==================================

// Module: vram_write_fifo
// PURPOSE
//  Buffers host (CPU/copper) 16-bit VRAM writes and drains them into the dual-bank vram
//  block (even/odd 16-bit SPRAM halves) only in arbiter-granted write slots.
//  Sits directly upstream of vram: drives its even/odd address, write enables and write_data.
//  Merges an even word and the following odd word of the same 32-bit pair into one dual-bank write.
// PARAMETERS
//  DEPTH        8  FIFO entries (power of 2, >=2); each entry = 15b word address + 16b data
//  PAIR_WRITES  1  1: merge even+odd pair into one slot; 0: always one entry per slot
// PORTS
//  clk             in   1   system clock
//  reset_n         in   1   async active-low reset
//  host_wr_valid   in   1   host write request
//  host_wr_ready   out  1   FIFO can accept (= !full)
//  host_wr_address in   15  16-bit word address; bit0 selects bank (0=even, 1=odd)
//  host_wr_data    in   16  write data
//  write_slot      in   1   arbiter grant: VRAM port is ours in the NEXT cycle
//  fifo_level      out  clog2(DEPTH)+1  entries held
//  fifo_empty      out  1   fifo_level==0
//  even_address    out  14  to vram even_address (registered)
//  odd_address     out  14  to vram odd_address (registered)
//  even_write_en   out  1   to vram even_write_en (registered)
//  odd_write_en    out  1   to vram odd_write_en (registered)
//  write_data      out  32  to vram write_data: [15:0] even bank, [31:16] odd bank (registered)
// BEHAVIOUR
//  Reset (async, reset_n low): FIFO flushed (level 0), all outputs 0, host_wr_ready=1 after release.
//  Push: host_wr_valid && host_wr_ready at edge N -> entry counted in fifo_level from N+1.
//   No full-bypass: when level==DEPTH, ready=0 even if a pop occurs that cycle.
//  Pop: at edge N with write_slot=1 and level>=1, head issued; outputs valid N+1..N+2 (one cycle).
//   Entry pushed at edge N is issuable at earliest by write_slot at edge N+1 (min latency 2 cycles).
//  Single issue, head address A: A[0]=0 -> even_write_en=1, even_address=A[14:1],
//   write_data={data,data}; A[0]=1 -> odd_write_en=1, odd_address=A[14:1], write_data={data,data}.
//  Pair issue (PAIR_WRITES=1): head A[0]=0, level>=2, next entry address == A|1 ->
//   both enables 1, both addresses A[14:1], write_data={next.data, head.data}; pops 2 entries.
//   Next entry's address != A|1 (incl. another even, or odd of another pair) -> single issue.
//  Idle cycle (no slot or empty): both enables 0; addresses and write_data hold last values.
//  Simultaneous push+pop: level = level+1-popped; pointers wrap modulo DEPTH without corruption.
//  Order preserved: entries reach vram strictly in push order; same-address writes land in order.
//  write_slot with empty FIFO: no effect. Reset mid-issue: enables drop to 0 immediately (async).
// TESTING
//  Push (0x0010,0xAAAA); slot -> one cycle even_write_en=1, even_address=0x0008,
//   write_data=0xAAAA_AAAA, odd_write_en=0; fifo_empty=1 afterward.
//  Push (0x0011,0x1234),(0x0010,0x5678); slots x2 -> odd write addr 0x0008 then even write
//   addr 0x0008 (odd-then-even never merged), two separate issue cycles.
//  Push (0x0020,0x1111),(0x0021,0x2222); one slot -> both enables, addresses 0x0010,
//   write_data=0x2222_1111, level 2->0; with PAIR_WRITES=0 -> two slots, two single writes.
//  Push 9 entries with write_slot=0 -> ready drops after 8th, 9th held off, fifo_level=8;
//   one slot -> ready returns next cycle; drain all, order and data match pushes.
//  Queue 4 entries, assert reset_n=0 mid-drain while enable high -> enables 0 same cycle,
//   fifo_level=0; post-reset slots produce no writes.
//  Random push/slot traffic 10k cycles vs. behavioural model of vram contents -> final
//   memory image identical, no write issued without preceding write_slot.

Source files
------------

// File: rtl/vram_write_fifo.sv
// Host write buffer in front of the dual-bank VRAM: queues 16-bit word writes and
// drains them only in arbiter-granted slots, merging an even/odd pair into one write.
module vram_write_fifo #(
  parameter int unsigned DEPTH       = 8,
  parameter bit          PAIR_WRITES = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       host_wr_valid,
  output logic                       host_wr_ready,
  input  logic [14:0]                host_wr_address,
  input  logic [15:0]                host_wr_data,
  input  logic                       write_slot,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       fifo_empty,
  output logic [13:0]                even_address,
  output logic [13:0]                odd_address,
  output logic                       even_write_en,
  output logic                       odd_write_en,
  output logic [31:0]                write_data
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  typedef struct packed {
    logic [14:0] addr;
    logic [15:0] data;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] rd_next_ptr;
  logic [LW-1:0] level_q, level_d;
  logic [LW-1:0] pop_count;

  logic [13:0]   even_address_q, even_address_d;
  logic [13:0]   odd_address_q, odd_address_d;
  logic          even_write_en_q, even_write_en_d;
  logic          odd_write_en_q, odd_write_en_d;
  logic [31:0]   write_data_q, write_data_d;

  entry_t        head_entry, nxt_entry;
  logic          push, issue, pair;

  // Full is judged on the registered level only: a pop in the same cycle does not
  // reopen the input, which keeps host_wr_ready free of any write_slot path.
  assign host_wr_ready = (level_q != LW'(DEPTH));
  assign push          = host_wr_valid && host_wr_ready;

  assign rd_next_ptr = rd_ptr_q + PW'(1);
  assign head_entry  = mem_q[rd_ptr_q];
  assign nxt_entry   = mem_q[rd_next_ptr];

  assign issue = write_slot && (level_q != '0);
  assign pair  = PAIR_WRITES && issue && !head_entry.addr[0] && (level_q >= LW'(2))
                 && (nxt_entry.addr == {head_entry.addr[14:1], 1'b1});

  // NOTE: every signal written here gets a default first, so no path leaves a value
  // unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    pop_count       = '0;
    even_write_en_d = 1'b0;
    odd_write_en_d  = 1'b0;
    even_address_d  = even_address_q;
    odd_address_d   = odd_address_q;
    write_data_d    = write_data_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);

    if (pair) begin
      pop_count       = LW'(2);
      even_write_en_d = 1'b1;
      odd_write_en_d  = 1'b1;
      even_address_d  = head_entry.addr[14:1];
      odd_address_d   = head_entry.addr[14:1];
      write_data_d    = {nxt_entry.data, head_entry.data};
    end else if (issue) begin
      pop_count    = LW'(1);
      write_data_d = {head_entry.data, head_entry.data};
      if (head_entry.addr[0]) begin
        odd_write_en_d = 1'b1;
        odd_address_d  = head_entry.addr[14:1];
      end else begin
        even_write_en_d = 1'b1;
        even_address_d  = head_entry.addr[14:1];
      end
    end

    rd_ptr_d = rd_ptr_q + PW'(pop_count);
    level_d  = level_q + LW'(push) - pop_count;
  end

  // NOTE: the entry storage has no reset; the level and pointers define which
  // entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{addr: host_wr_address, data: host_wr_data};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values computed above, independent of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      level_q         <= '0;
      even_address_q  <= '0;
      odd_address_q   <= '0;
      even_write_en_q <= 1'b0;
      odd_write_en_q  <= 1'b0;
      write_data_q    <= '0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      level_q         <= level_d;
      even_address_q  <= even_address_d;
      odd_address_q   <= odd_address_d;
      even_write_en_q <= even_write_en_d;
      odd_write_en_q  <= odd_write_en_d;
      write_data_q    <= write_data_d;
    end
  end

  assign fifo_level    = level_q;
  assign fifo_empty    = (level_q == '0);
  assign even_address  = even_address_q;
  assign odd_address   = odd_address_q;
  assign even_write_en = even_write_en_q;
  assign odd_write_en  = odd_write_en_q;
  assign write_data    = write_data_q;

endmodule

// File: tb/tb_vram_write_fifo.sv
// Self-checking bench for vram_write_fifo: directed scenarios on merged and unmerged
// instances, then randomized traffic against a queue-based model of VRAM contents.
module tb_vram_write_fifo;

  logic        clk;
  logic        reset_n;
  logic        host_wr_valid;
  logic [14:0] host_wr_address;
  logic [15:0] host_wr_data;
  logic        write_slot;

  logic        host_wr_ready, fifo_empty, even_write_en, odd_write_en;
  logic [3:0]  fifo_level;
  logic [13:0] even_address, odd_address;
  logic [31:0] write_data;

  logic        np_ready, np_empty, np_even_we, np_odd_we;
  logic [3:0]  np_level;
  logic [13:0] np_even_addr, np_odd_addr;
  logic [31:0] np_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [14:0] a;
    logic [15:0] d;
  } ent_t;

  logic [15:0] model_mem [32768];
  logic [15:0] dut_mem   [32768];

  vram_write_fifo #(.DEPTH(8), .PAIR_WRITES(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
    .host_wr_address(host_wr_address), .host_wr_data(host_wr_data),
    .write_slot(write_slot), .fifo_level(fifo_level), .fifo_empty(fifo_empty),
    .even_address(even_address), .odd_address(odd_address),
    .even_write_en(even_write_en), .odd_write_en(odd_write_en),
    .write_data(write_data)
  );

  vram_write_fifo #(.DEPTH(8), .PAIR_WRITES(1'b0)) dut_np (
    .clk(clk), .reset_n(reset_n),
    .host_wr_valid(host_wr_valid), .host_wr_ready(np_ready),
    .host_wr_address(host_wr_address), .host_wr_data(host_wr_data),
    .write_slot(write_slot), .fifo_level(np_level), .fifo_empty(np_empty),
    .even_address(np_even_addr), .odd_address(np_odd_addr),
    .even_write_en(np_even_we), .odd_write_en(np_odd_we),
    .write_data(np_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [14:0] a, input logic [15:0] d);
    host_wr_valid   = 1'b1;
    host_wr_address = a;
    host_wr_data    = d;
    tick();
    host_wr_valid   = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b1; host_wr_valid = 1'b0; host_wr_address = '0; host_wr_data = '0;
    write_slot = 1'b0;
    #2 reset_n = 1'b0;
    #2;
    checks++;
    if (fifo_level !== 4'd0 || fifo_empty !== 1'b1) begin
      errors++; $display("FAIL reset_level: level=%0d empty=%b, want 0/1", fifo_level, fifo_empty);
    end
    checks++;
    if ({even_write_en, odd_write_en, even_address, odd_address, write_data} !== '0) begin
      errors++; $display("FAIL reset_outputs: we=%b%b ea=%h oa=%h wd=%h, want all 0",
                         even_write_en, odd_write_en, even_address, odd_address, write_data);
    end
    tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (host_wr_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: ready=%b, want 1", host_wr_ready);
    end
  endtask

  task automatic test_single();
    // Push together with a slot on an empty FIFO: the slot must be ignored.
    host_wr_valid = 1'b1; host_wr_address = 15'h0010; host_wr_data = 16'hAAAA;
    write_slot = 1'b1;
    tick();
    host_wr_valid = 1'b0;
    checks++;
    if (even_write_en !== 1'b0 || odd_write_en !== 1'b0 || fifo_level !== 4'd1) begin
      errors++; $display("FAIL single_empty_slot: we=%b%b level=%0d, want 00/1",
                         even_write_en, odd_write_en, fifo_level);
    end
    tick();
    write_slot = 1'b0;
    checks++;
    if (even_write_en !== 1'b1 || odd_write_en !== 1'b0 || even_address !== 14'h0008 ||
        write_data !== 32'hAAAA_AAAA) begin
      errors++; $display("FAIL single_issue: we=%b%b ea=%h wd=%h, want 10/0008/aaaaaaaa",
                         even_write_en, odd_write_en, even_address, write_data);
    end
    checks++;
    if (fifo_empty !== 1'b1) begin
      errors++; $display("FAIL single_empty: empty=%b, want 1", fifo_empty);
    end
    tick();
    checks++;
    if (even_write_en !== 1'b0 || even_address !== 14'h0008 || write_data !== 32'hAAAA_AAAA) begin
      errors++; $display("FAIL single_hold: we=%b ea=%h wd=%h, want 0/0008/aaaaaaaa",
                         even_write_en, even_address, write_data);
    end
  endtask

  task automatic test_odd_even();
    push_one(15'h0011, 16'h1234);
    push_one(15'h0010, 16'h5678);
    write_slot = 1'b1;
    tick();
    checks++;
    if (odd_write_en !== 1'b1 || even_write_en !== 1'b0 || odd_address !== 14'h0008 ||
        write_data !== 32'h1234_1234) begin
      errors++; $display("FAIL oddeven_first: we=%b%b oa=%h wd=%h, want 01/0008/12341234",
                         even_write_en, odd_write_en, odd_address, write_data);
    end
    tick();
    write_slot = 1'b0;
    checks++;
    if (even_write_en !== 1'b1 || odd_write_en !== 1'b0 || even_address !== 14'h0008 ||
        write_data !== 32'h5678_5678) begin
      errors++; $display("FAIL oddeven_second: we=%b%b ea=%h wd=%h, want 10/0008/56785678",
                         even_write_en, odd_write_en, even_address, write_data);
    end
    checks++;
    if (np_even_we !== 1'b1 || np_even_addr !== 14'h0008 || np_data !== 32'h5678_5678) begin
      errors++; $display("FAIL oddeven_np: we=%b ea=%h wd=%h, want 1/0008/56785678",
                         np_even_we, np_even_addr, np_data);
    end
    tick();
  endtask

  task automatic test_pair();
    push_one(15'h0020, 16'h1111);
    push_one(15'h0021, 16'h2222);
    checks++;
    if (fifo_level !== 4'd2) begin
      errors++; $display("FAIL pair_level_before: level=%0d, want 2", fifo_level);
    end
    write_slot = 1'b1;
    tick();
    checks++;
    if (even_write_en !== 1'b1 || odd_write_en !== 1'b1 || even_address !== 14'h0010 ||
        odd_address !== 14'h0010 || write_data !== 32'h2222_1111 || fifo_level !== 4'd0) begin
      errors++; $display("FAIL pair_issue: we=%b%b ea=%h oa=%h wd=%h lvl=%0d, want 11/0010/0010/22221111/0",
                         even_write_en, odd_write_en, even_address, odd_address, write_data, fifo_level);
    end
    checks++;
    if (np_even_we !== 1'b1 || np_odd_we !== 1'b0 || np_data !== 32'h1111_1111 || np_level !== 4'd1) begin
      errors++; $display("FAIL pair_np_first: we=%b%b wd=%h lvl=%0d, want 10/11111111/1",
                         np_even_we, np_odd_we, np_data, np_level);
    end
    tick();
    write_slot = 1'b0;
    checks++;
    if (even_write_en !== 1'b0 || odd_write_en !== 1'b0) begin
      errors++; $display("FAIL pair_after_idle: we=%b%b, want 00", even_write_en, odd_write_en);
    end
    checks++;
    if (np_odd_we !== 1'b1 || np_even_we !== 1'b0 || np_odd_addr !== 14'h0010 || np_data !== 32'h2222_2222) begin
      errors++; $display("FAIL pair_np_second: we=%b%b oa=%h wd=%h, want 01/0010/22222222",
                         np_even_we, np_odd_we, np_odd_addr, np_data);
    end
    // Even followed by the odd word of a different pair must not merge.
    push_one(15'h0030, 16'hBEEF);
    push_one(15'h0033, 16'hCAFE);
    write_slot = 1'b1;
    tick();
    write_slot = 1'b0;
    checks++;
    if (even_write_en !== 1'b1 || odd_write_en !== 1'b0 || fifo_level !== 4'd1) begin
      errors++; $display("FAIL pair_nonmatch: we=%b%b lvl=%0d, want 10/1",
                         even_write_en, odd_write_en, fifo_level);
    end
    write_slot = 1'b1;
    tick();
    tick();
    write_slot = 1'b0;
    tick();
  endtask

  task automatic test_full();
    logic [13:0] got_a [$];
    logic [15:0] got_d [$];
    for (int i = 0; i < 9; i++) begin
      host_wr_valid   = 1'b1;
      host_wr_address = 15'(16'h0100 + 2 * i);
      host_wr_data    = 16'(16'hC000 + i);
      checks++;
      if (host_wr_ready !== (i < 8)) begin
        errors++; $display("FAIL full_ready_%0d: ready=%b, want %b", i, host_wr_ready, (i < 8));
      end
      tick();
    end
    checks++;
    if (fifo_level !== 4'd8 || host_wr_ready !== 1'b0) begin
      errors++; $display("FAIL full_level: level=%0d ready=%b, want 8/0", fifo_level, host_wr_ready);
    end
    // Slot while full with the 9th still offered: the pop does not admit it this edge.
    write_slot = 1'b1;
    tick();
    write_slot = 1'b0;
    got_a.push_back(even_address);
    got_d.push_back(write_data[15:0]);
    checks++;
    if (even_write_en !== 1'b1 || fifo_level !== 4'd7 || host_wr_ready !== 1'b1) begin
      errors++; $display("FAIL full_pop: we=%b lvl=%0d ready=%b, want 1/7/1",
                         even_write_en, fifo_level, host_wr_ready);
    end
    tick();
    host_wr_valid = 1'b0;
    checks++;
    if (fifo_level !== 4'd8) begin
      errors++; $display("FAIL full_refill: level=%0d, want 8", fifo_level);
    end
    write_slot = 1'b1;
    for (int c = 0; c < 20 && got_a.size() < 9; c++) begin
      tick();
      if (even_write_en) begin
        got_a.push_back(even_address);
        got_d.push_back(write_data[15:0]);
      end
    end
    write_slot = 1'b0;
    checks++;
    if (got_a.size() != 9) begin
      errors++; $display("FAIL full_drain_count: got=%0d, want 9", got_a.size());
    end
    for (int i = 0; i < got_a.size(); i++) begin
      checks++;
      if (got_a[i] !== 14'(14'h0080 + i) || got_d[i] !== 16'(16'hC000 + i)) begin
        errors++; $display("FAIL full_order_%0d: addr=%h data=%h, want %h/%h",
                           i, got_a[i], got_d[i], 14'(14'h0080 + i), 16'(16'hC000 + i));
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) push_one(15'(16'h0200 + 2 * i), 16'(16'hD000 + i));
    write_slot = 1'b1;
    tick();
    checks++;
    if (even_write_en !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre: we=%b, want 1", even_write_en);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (even_write_en !== 1'b0 || odd_write_en !== 1'b0 || fifo_level !== 4'd0 || fifo_empty !== 1'b1) begin
      errors++; $display("FAIL rstmid_async: we=%b%b lvl=%0d empty=%b, want 00/0/1",
                         even_write_en, odd_write_en, fifo_level, fifo_empty);
    end
    #2 reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (even_write_en !== 1'b0 || odd_write_en !== 1'b0 || fifo_level !== 4'd0) begin
        errors++; $display("FAIL rstmid_post_%0d: we=%b%b lvl=%0d, want 00/0",
                           c, even_write_en, odd_write_en, fifo_level);
      end
    end
    write_slot = 1'b0;
  endtask

  task automatic test_random();
    ent_t mq[$];
    ent_t h, n;
    logic exp_rdy, e_we, o_we;
    logic [13:0] e_a, o_a;
    logic [31:0] e_d;
    int diffs;
    for (int i = 0; i < 32768; i++) begin
      model_mem[i] = '0;
      dut_mem[i]   = '0;
    end
    for (int cyc = 0; cyc < 10060; cyc++) begin
      if (cyc < 10000) begin
        host_wr_valid = ($urandom_range(0, 99) < 60);
        write_slot    = ($urandom_range(0, 99) < 45);
      end else begin
        host_wr_valid = 1'b0;
        write_slot    = 1'b1;
      end
      host_wr_address = 15'($urandom_range(0, 31));
      host_wr_data    = 16'($urandom);
      exp_rdy = (mq.size() < 8);
      checks++;
      if (host_wr_ready !== exp_rdy) begin
        errors++; $display("FAIL rnd_ready@%0d: ready=%b, want %b", cyc, host_wr_ready, exp_rdy);
      end
      e_we = 1'b0; o_we = 1'b0; e_a = '0; o_a = '0; e_d = '0;
      if (write_slot && mq.size() > 0) begin
        h = mq.pop_front();
        if (!h.a[0] && mq.size() > 0 && mq[0].a == (h.a | 15'd1)) begin
          n = mq.pop_front();
          e_we = 1'b1; o_we = 1'b1; e_a = h.a[14:1]; o_a = h.a[14:1]; e_d = {n.d, h.d};
          model_mem[h.a] = h.d;
          model_mem[n.a] = n.d;
        end else begin
          if (h.a[0]) begin o_we = 1'b1; o_a = h.a[14:1]; end
          else begin e_we = 1'b1; e_a = h.a[14:1]; end
          e_d = {h.d, h.d};
          model_mem[h.a] = h.d;
        end
      end
      if (host_wr_valid && exp_rdy) mq.push_back('{host_wr_address, host_wr_data});
      tick();
      checks++;
      if (even_write_en !== e_we || odd_write_en !== o_we ||
          (e_we && even_address !== e_a) || (o_we && odd_address !== o_a) ||
          ((e_we || o_we) && write_data !== e_d) || fifo_level !== 4'(mq.size())) begin
        errors++;
        $display("FAIL rnd_issue@%0d: we=%b%b ea=%h oa=%h wd=%h lvl=%0d, want %b%b/%h/%h/%h/%0d",
                 cyc, even_write_en, odd_write_en, even_address, odd_address, write_data,
                 fifo_level, e_we, o_we, e_a, o_a, e_d, mq.size());
      end
      if (even_write_en) dut_mem[{even_address, 1'b0}] = write_data[15:0];
      if (odd_write_en)  dut_mem[{odd_address, 1'b1}]  = write_data[31:16];
    end
    write_slot = 1'b0;
    checks++;
    if (mq.size() != 0 || fifo_empty !== 1'b1) begin
      errors++; $display("FAIL rnd_drained: model=%0d empty=%b, want 0/1", mq.size(), fifo_empty);
    end
    diffs = 0;
    for (int i = 0; i < 32768; i++) if (dut_mem[i] !== model_mem[i]) diffs++;
    checks++;
    if (diffs != 0) begin
      errors++; $display("FAIL rnd_mem_image: %0d differing words, want 0", diffs);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_odd_even();
    test_pair();
    test_full();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
